// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings and control-bundle types for the ctrl_pipe pipeline registers
// Contents: ALUOp classes, EX operand forwarding selects, and the EX/MEM/WB control structs
// with their bubble constants. Feature macro used by the importing RTL: CTRL_FWD_EN.
package ctrl_pkg;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ex_ctrl_t;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam ex_ctrl_t  EX_BUBBLE  = '0;
    localparam mem_ctrl_t MEM_BUBBLE = '0;
    localparam wb_ctrl_t  WB_BUBBLE  = '0;
endpackage

// File: rtl/ctrl_pipe_hazard.sv
// hazard_unit: combinational stall and EX operand-forwarding selects
// Inputs : ID valid/rs1/rs2, flush, and the valid/control/register fields of EX, MEM and WB.
// Outputs: stall (hold PC and IF/ID), fwd_a/fwd_b (EX operand source select).
// CTRL_FWD_EN defined  : forwarding from MEM (priority) or WB; stall only on load-use.
// CTRL_FWD_EN undefined: no forwarding; stall on any RAW against a writer in EX or MEM.
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);
    // x0 is never a producer, so rd==0 can never match.
    function automatic logic hit(input logic v, input logic we,
                                 input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
        return v & we & (rd != '0) & (rd == rs);
    endfunction

`ifdef CTRL_FWD_EN
    logic luh;
    logic unused_fwd;
    assign luh = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign stall = luh & ~flush;
    assign fwd_a = hit(mem_valid, mem_reg_write, mem_rd, ex_rs1) ? FWD_MEM :
                   hit(wb_valid, wb_reg_write, wb_rd, ex_rs1)    ? FWD_WB  : FWD_RF;
    assign fwd_b = hit(mem_valid, mem_reg_write, mem_rd, ex_rs2) ? FWD_MEM :
                   hit(wb_valid, wb_reg_write, wb_rd, ex_rs2)    ? FWD_WB  : FWD_RF;
    assign unused_fwd = ex_reg_write;
`else
    logic dep;
    logic unused_nofwd;
    // WB needs no stall: the register file writes before it reads.
    assign dep = hit(ex_valid, ex_reg_write, ex_rd, id_rs1) |
                 hit(ex_valid, ex_reg_write, ex_rd, id_rs2) |
                 hit(mem_valid, mem_reg_write, mem_rd, id_rs1) |
                 hit(mem_valid, mem_reg_write, mem_rd, id_rs2);
    assign stall = id_valid & dep & ~flush;
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
    assign unused_nofwd = ^{ex_mem_read, ex_rs1, ex_rs2, wb_valid, wb_reg_write, wb_rd};
`endif
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM and MEM/WB control-bundle registers with hazard and forwarding control
// Inputs : clk, rst (async, active-high), id_valid, decoder controls id_*, id_rs1/rs2/rd, flush.
// Outputs: stall, ex_* (valid, Branch, ALUSrc, ALUOp, rs1, rs2, rd), fwd_a/fwd_b,
//          mem_* (valid, MemRead, MemWrite, MemtoReg, RegWrite, rd), wb_* (valid, MemtoReg, RegWrite, rd).
// CTRL_FWD_EN selects the forwarding variant of hazard_unit; undefined builds a stall-only pipe.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_Branch,
    input  logic              id_MemRead,
    input  logic              id_MemtoReg,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic              id_RegWrite,
    input  logic [1:0]        id_ALUOp,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_Branch,
    output logic              ex_ALUSrc,
    output logic [1:0]        ex_ALUOp,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_valid,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic              mem_MemtoReg,
    output logic              mem_RegWrite,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_valid,
    output logic              wb_MemtoReg,
    output logic              wb_RegWrite,
    output logic [REG_AW-1:0] wb_rd
);
    ex_ctrl_t          ex_d, ex_q;
    mem_ctrl_t         mem_d, mem_q;
    wb_ctrl_t          wb_d, wb_q;
    logic [REG_AW-1:0] ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q, ex_rd_d, ex_rd_q;
    logic [REG_AW-1:0] mem_rd_d, mem_rd_q, wb_rd_d, wb_rd_q;
    logic              take;

    hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .flush         (flush),
        .ex_valid      (ex_q.valid),
        .ex_mem_read   (ex_q.mem_read),
        .ex_reg_write  (ex_q.reg_write),
        .ex_rd         (ex_rd_q),
        .ex_rs1        (ex_rs1_q),
        .ex_rs2        (ex_rs2_q),
        .mem_valid     (mem_q.valid),
        .mem_reg_write (mem_q.reg_write),
        .mem_rd        (mem_rd_q),
        .wb_valid      (wb_q.valid),
        .wb_reg_write  (wb_q.reg_write),
        .wb_rd         (wb_rd_q),
        .stall         (stall),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // stall is already masked by flush, so either one alone turns ID/EX into a bubble.
    assign take = id_valid & ~flush & ~stall;

    always_comb begin
        ex_d     = take ? ex_ctrl_t'{valid: 1'b1, branch: id_Branch, alu_src: id_ALUSrc,
                                     alu_op: id_ALUOp, mem_read: id_MemRead, mem_write: id_MemWrite,
                                     mem_to_reg: id_MemtoReg, reg_write: id_RegWrite} : EX_BUBBLE;
        ex_rs1_d = take ? id_rs1 : '0;
        ex_rs2_d = take ? id_rs2 : '0;
        ex_rd_d  = take ? id_rd : '0;
        mem_d    = mem_ctrl_t'{valid: ex_q.valid, mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                               mem_to_reg: ex_q.mem_to_reg, reg_write: ex_q.reg_write};
        mem_rd_d = ex_rd_q;
        wb_d     = wb_ctrl_t'{valid: mem_q.valid, mem_to_reg: mem_q.mem_to_reg,
                              reg_write: mem_q.reg_write};
        wb_rd_d  = mem_rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= EX_BUBBLE;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_rd_q  <= '0;
            mem_q    <= MEM_BUBBLE;
            mem_rd_q <= '0;
            wb_q     <= WB_BUBBLE;
            wb_rd_q  <= '0;
        end else begin
            ex_q     <= ex_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            ex_rd_q  <= ex_rd_d;
            mem_q    <= mem_d;
            mem_rd_q <= mem_rd_d;
            wb_q     <= wb_d;
            wb_rd_q  <= wb_rd_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_Branch    = ex_q.branch;
    assign ex_ALUSrc    = ex_q.alu_src;
    assign ex_ALUOp     = ex_q.alu_op;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign mem_valid    = mem_q.valid;
    assign mem_MemRead  = mem_q.mem_read;
    assign mem_MemWrite = mem_q.mem_write;
    assign mem_MemtoReg = mem_q.mem_to_reg;
    assign mem_RegWrite = mem_q.reg_write;
    assign mem_rd       = mem_rd_q;
    assign wb_valid     = wb_q.valid;
    assign wb_MemtoReg  = wb_q.mem_to_reg;
    assign wb_RegWrite  = wb_q.reg_write;
    assign wb_rd        = wb_rd_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed self-checking bench for ctrl_pipe (expectations follow CTRL_FWD_EN)
module tb_ctrl_pipe;
  import ctrl_pkg::*;
`ifdef CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic       clk = 1'b0, rst, id_valid, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite;
  logic       id_ALUSrc, id_RegWrite, flush, stall, ex_valid, ex_Branch, ex_ALUSrc;
  logic [1:0] id_ALUOp, ex_ALUOp, fwd_a, fwd_b;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       mem_valid, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite;
  logic       wb_valid, wb_MemtoReg, wb_RegWrite;
  int         errors = 0, checks = 0;
  always #5 clk = ~clk;
  ctrl_pipe #(.REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
    .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
    .id_RegWrite(id_RegWrite), .id_ALUOp(id_ALUOp), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_Branch(ex_Branch),
    .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_valid(mem_valid), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg), .mem_RegWrite(mem_RegWrite),
    .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
    .wb_rd(wb_rd)
  );
  task automatic set(input logic v, br, mr, m2r, mw, as, rw, input logic [1:0] op,
                     input logic [4:0] a, b, d);
    id_valid = v; id_Branch = br; id_MemRead = mr; id_MemtoReg = m2r; id_MemWrite = mw;
    id_ALUSrc = as; id_RegWrite = rw; id_ALUOp = op; id_rs1 = a; id_rs2 = b; id_rd = d;
  endtask
  task automatic nop();                            set(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0); endtask
  task automatic rtype(input logic [4:0] a, b, d); set(1, 0, 0, 0, 0, 0, 1, ALUOP_FUNCT, a, b, d); endtask
  task automatic load(input logic [4:0] a, d);     set(1, 0, 1, 1, 0, 1, 1, ALUOP_ADD, a, 0, d); endtask
  task automatic store(input logic [4:0] a, b);    set(1, 0, 0, 0, 1, 1, 0, ALUOP_ADD, a, b, 0); endtask
  task automatic branch(input logic [4:0] a, b);   set(1, 1, 0, 0, 0, 0, 0, ALUOP_BR, a, b, 0); endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    nop();
    repeat (3) tick();
  endtask
  initial begin
    #100000;
    errors++;
    $error("FAIL timeout: test sequence did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    nop();
    flush = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if ({ex_valid, mem_valid, wb_valid, stall, fwd_a, fwd_b} !== 7'b0) begin
      errors++;
      $error("FAIL reset_state: ex=%b mem=%b wb=%b stall=%b fwd_a=%b fwd_b=%b",
             ex_valid, mem_valid, wb_valid, stall, fwd_a, fwd_b);
    end
    checks++; if (ex_valid !== 1'b0) begin errors++; $error("FAIL rst_ex_valid: %0h", ex_valid); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $error("FAIL rst_mem_valid: %0h", mem_valid); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $error("FAIL rst_wb_valid: %0h", wb_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $error("FAIL rst_stall: %0h", stall); end
    checks++; if (fwd_a !== FWD_RF) begin errors++; $error("FAIL rst_fwd_a: %0h", fwd_a); end
    @(negedge clk);
    rst = 1'b0;
    rtype(1, 2, 5); #1;
    checks++; if (stall !== 1'b0) begin errors++; $error("FAIL exmem_first_stall: %0h", stall); end
    tick();
    rtype(5, 5, 6); #1;
    checks++; if (stall !== (FWD ? 1'b0 : 1'b1)) begin errors++; $error("FAIL exmem_stall: %0h", stall); end
    checks++; if (ex_rd !== 5'd5) begin errors++; $error("FAIL exmem_ex_rd: %0h", ex_rd); end
    checks++; if (ex_ALUOp !== ALUOP_FUNCT) begin errors++; $error("FAIL exmem_ex_aluop: %0h", ex_ALUOp); end
    tick();
    nop(); #1;
    checks++; if (fwd_a !== (FWD ? FWD_MEM : FWD_RF)) begin errors++; $error("FAIL exmem_fwd_a: %0h", fwd_a); end
    checks++; if (fwd_b !== (FWD ? FWD_MEM : FWD_RF)) begin errors++; $error("FAIL exmem_fwd_b: %0h", fwd_b); end
    checks++; if (ex_valid !== (FWD ? 1'b1 : 1'b0)) begin errors++; $error("FAIL exmem_ex_valid: %0h", ex_valid); end
    checks++; if (mem_rd !== 5'd5) begin errors++; $error("FAIL exmem_mem_rd: %0h", mem_rd); end
    checks++; if (mem_RegWrite !== 1'b1) begin errors++; $error("FAIL exmem_mem_regwrite: %0h", mem_RegWrite); end
    tick();
    checks++; if (wb_valid !== 1'b1) begin errors++; $error("FAIL exmem_wb_valid: %0h", wb_valid); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $error("FAIL exmem_wb_rd: %0h", wb_rd); end
    checks++; if (wb_RegWrite !== 1'b1) begin errors++; $error("FAIL exmem_wb_regwrite: %0h", wb_RegWrite); end
    drain();
    rtype(1, 2, 5); tick();
    rtype(3, 4, 8); #1;
    checks++; if (stall !== 1'b0) begin errors++; $error("FAIL memwb_gap_stall: %0h", stall); end
    tick();
    rtype(5, 9, 10); #1;
    checks++; if (stall !== (FWD ? 1'b0 : 1'b1)) begin errors++; $error("FAIL memwb_stall: %0h", stall); end
    tick();
    nop(); #1;
    checks++; if (fwd_a !== (FWD ? FWD_WB : FWD_RF)) begin errors++; $error("FAIL memwb_fwd_a: %0h", fwd_a); end
    checks++; if (fwd_b !== FWD_RF) begin errors++; $error("FAIL memwb_fwd_b: %0h", fwd_b); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $error("FAIL memwb_wb_rd: %0h", wb_rd); end
    drain();
    rtype(1, 2, 5); tick();
    rtype(1, 1, 5); tick();
    rtype(5, 0, 11); #1;
    checks++; if (stall !== (FWD ? 1'b0 : 1'b1)) begin errors++; $error("FAIL young_stall: %0h", stall); end
    tick();
    nop(); #1;
    checks++; if (fwd_a !== (FWD ? FWD_MEM : FWD_RF)) begin errors++; $error("FAIL young_fwd_a: %0h", fwd_a); end
    checks++; if (fwd_b !== FWD_RF) begin errors++; $error("FAIL young_fwd_b: %0h", fwd_b); end
    drain();
    load(1, 7); tick();
    rtype(3, 7, 12); #1;
    checks++; if (stall !== 1'b1) begin errors++; $error("FAIL lu_stall: %0h", stall); end
    checks++; if (ex_ALUSrc !== 1'b1) begin errors++; $error("FAIL lu_ex_alusrc: %0h", ex_ALUSrc); end
    checks++; if (ex_ALUOp !== ALUOP_ADD) begin errors++; $error("FAIL lu_ex_aluop: %0h", ex_ALUOp); end
    tick();
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $error("FAIL lu_bubble_ex_valid: %0h", ex_valid); end
    checks++; if (stall !== (FWD ? 1'b0 : 1'b1)) begin errors++; $error("FAIL lu_second_stall: %0h", stall); end
    checks++; if (mem_MemRead !== 1'b1) begin errors++; $error("FAIL lu_mem_memread: %0h", mem_MemRead); end
    checks++; if (mem_MemtoReg !== 1'b1) begin errors++; $error("FAIL lu_mem_memtoreg: %0h", mem_MemtoReg); end
    tick();
    if (FWD) nop();
    #1;
    checks++; if (ex_valid !== (FWD ? 1'b1 : 1'b0)) begin errors++; $error("FAIL lu_dep_ex_valid: %0h", ex_valid); end
    checks++; if (fwd_b !== (FWD ? FWD_WB : FWD_RF)) begin errors++; $error("FAIL lu_fwd_b: %0h", fwd_b); end
    checks++; if (stall !== 1'b0) begin errors++; $error("FAIL lu_after_stall: %0h", stall); end
    checks++; if (wb_MemtoReg !== 1'b1) begin errors++; $error("FAIL lu_wb_memtoreg: %0h", wb_MemtoReg); end
    checks++; if (wb_rd !== 5'd7) begin errors++; $error("FAIL lu_wb_rd: %0h", wb_rd); end
    tick();
    nop(); #1;
    checks++; if (ex_rd !== (FWD ? 5'd0 : 5'd12)) begin errors++; $error("FAIL lu_late_ex_rd: %0h", ex_rd); end
    drain();
    rtype(1, 2, 0); tick();
    rtype(0, 0, 13); #1;
    checks++; if (stall !== 1'b0) begin errors++; $error("FAIL x0_stall: %0h", stall); end
    tick();
    nop(); #1;
    checks++; if (fwd_a !== FWD_RF) begin errors++; $error("FAIL x0_fwd_a: %0h", fwd_a); end
    checks++; if (fwd_b !== FWD_RF) begin errors++; $error("FAIL x0_fwd_b: %0h", fwd_b); end
    checks++; if (ex_rd !== 5'd13) begin errors++; $error("FAIL x0_ex_rd: %0h", ex_rd); end
    drain();
    load(1, 0); tick();
    rtype(0, 0, 14); #1;
    checks++; if (stall !== 1'b0) begin errors++; $error("FAIL x0_load_stall: %0h", stall); end
    drain();
    store(1, 2); tick();
    nop(); #1;
    checks++; if (ex_ALUSrc !== 1'b1) begin errors++; $error("FAIL st_ex_alusrc: %0h", ex_ALUSrc); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $error("FAIL st_ex_rd: %0h", ex_rd); end
    tick();
    checks++; if (mem_MemWrite !== 1'b1) begin errors++; $error("FAIL st_mem_memwrite: %0h", mem_MemWrite); end
    checks++; if (mem_RegWrite !== 1'b0) begin errors++; $error("FAIL st_mem_regwrite: %0h", mem_RegWrite); end
    drain();
    load(1, 7); tick();
    rtype(7, 3, 15); flush = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $error("FAIL fl_lu_stall: %0h", stall); end
    tick();
    flush = 1'b0; nop(); #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $error("FAIL fl_lu_ex_valid: %0h", ex_valid); end
    checks++; if (mem_valid !== 1'b1) begin errors++; $error("FAIL fl_lu_mem_valid: %0h", mem_valid); end
    checks++; if (mem_MemRead !== 1'b1) begin errors++; $error("FAIL fl_lu_mem_memread: %0h", mem_MemRead); end
    checks++; if (mem_rd !== 5'd7) begin errors++; $error("FAIL fl_lu_mem_rd: %0h", mem_rd); end
    drain();
    branch(1, 2); tick();
    rtype(3, 4, 16); flush = 1'b1; #1;
    checks++; if (ex_Branch !== 1'b1) begin errors++; $error("FAIL br_ex_branch: %0h", ex_Branch); end
    checks++; if (ex_ALUOp !== ALUOP_BR) begin errors++; $error("FAIL br_ex_aluop: %0h", ex_ALUOp); end
    tick();
    flush = 1'b0; nop(); #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $error("FAIL br_ex_valid: %0h", ex_valid); end
    checks++; if (mem_valid !== 1'b1) begin errors++; $error("FAIL br_mem_valid: %0h", mem_valid); end
    checks++; if (mem_RegWrite !== 1'b0) begin errors++; $error("FAIL br_mem_regwrite: %0h", mem_RegWrite); end
    drain();
    rtype(1, 2, 17); tick();
    load(1, 18); tick();
    rtype(18, 3, 19); #1;
    checks++; if (stall !== 1'b1) begin errors++; $error("FAIL mid_pre_stall: %0h", stall); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $error("FAIL mid_rst_ex_valid: %0h", ex_valid); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $error("FAIL mid_rst_mem_valid: %0h", mem_valid); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $error("FAIL mid_rst_wb_valid: %0h", wb_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $error("FAIL mid_rst_stall: %0h", stall); end
    checks++; if (fwd_a !== FWD_RF) begin errors++; $error("FAIL mid_rst_fwd_a: %0h", fwd_a); end
    checks++; if (mem_rd !== 5'd0) begin errors++; $error("FAIL mid_rst_mem_rd: %0h", mem_rd); end
    @(negedge clk);
    rst = 1'b0;
    nop();
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $error("FAIL post_rst_mem_valid: %0h", mem_valid); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $error("FAIL post_rst_wb_valid: %0h", wb_valid); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
